// File: rtl/swc_rd_sched.sv
// Weighted round-robin read scheduler: picks one queue head per cell for the shared
// SRAM read engine, honouring back-pressure, per-port cell weights and packet locks.
module swc_rd_sched #(
  parameter int NPORT      = 4,
  parameter int WW         = 4,
  parameter int DEF_WEIGHT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req,
  input  logic [NPORT-1:0] req_last,
  input  logic [NPORT-1:0] bp,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_port,
  input  logic [WW-1:0]    cfg_weight,
  output logic             gnt_valid,
  output logic [NPORT-1:0] gnt_sel,
  output logic             gnt_last,
  input  logic             gnt_ack,
  input  logic             cell_done,
  output logic             busy
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_REFILL,
    S_GRANT,
    S_WAIT
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WW-1:0]      r_weight [NPORT];
  logic [WW-1:0]      r_credit [NPORT];
  logic [NPORT-1:0]   r_gnt_sel;
  logic               r_gnt_last;
  logic [PW-1:0]      r_sel_idx;
  logic [PW-1:0]      r_rr_ptr;
  logic               r_lock;
  logic [PW-1:0]      r_lock_port;

  logic [NPORT-1:0]   w_wnz;
  logic [NPORT-1:0]   w_cnz;
  logic [NPORT-1:0]   w_elig;
  logic [NPORT-1:0]   w_cand;
  logic               w_lock_hit;
  logic               w_found;
  logic [PW-1:0]      w_pick;
  logic [PW-1:0]      w_sel_idx;
  logic               w_do_sel;
  logic               w_ack;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
    return PW'((32'(base) + off) % NPORT);
  endfunction

  always_comb begin
    w_wnz = '0;
    w_cnz = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      w_wnz[i] = (r_weight[i] != '0);
      w_cnz[i] = (r_credit[i] != '0);
    end
  end

  assign w_elig     = req & ~bp & w_wnz;
  assign w_cand     = w_elig & w_cnz;
  assign w_lock_hit = r_lock && w_elig[r_lock_port];

  // Circular first-set search of cand starting at rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      if (!w_found && w_cand[wrap_add(r_rr_ptr, k)]) begin
        w_found = 1'b1;
        w_pick  = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign w_sel_idx = w_lock_hit ? r_lock_port : w_pick;
  assign w_ack     = (r_state == S_GRANT) && gnt_ack;

  // IDLE jumps straight to REFILL when nothing has credit, so a refill costs one extra cycle.
  always_comb begin
    w_next   = r_state;
    w_do_sel = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_elig != '0) begin
          w_next = (w_lock_hit || (w_cand != '0)) ? S_ARB : S_REFILL;
        end
      end
      S_ARB: begin
        if (w_lock_hit) begin
          w_do_sel = 1'b1;
          w_next   = S_GRANT;
        end else if (w_elig == '0) begin
          w_next = S_IDLE;
        end else if (w_cand == '0) begin
          w_next = S_REFILL;
        end else begin
          w_do_sel = 1'b1;
          w_next   = S_GRANT;
        end
      end
      S_REFILL: w_next = S_ARB;
      S_GRANT: begin
        if (gnt_ack) begin
          w_next = S_WAIT;
        end else if ((w_elig & r_gnt_sel) == '0) begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cell_done) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt_sel   <= '0;
      r_gnt_last  <= 1'b0;
      r_sel_idx   <= '0;
      r_rr_ptr    <= '0;
      r_lock      <= 1'b0;
      r_lock_port <= '0;
      for (int unsigned i = 0; i < NPORT; i++) begin
        r_credit[i] <= '0;
        r_weight[i] <= WW'(DEF_WEIGHT);
      end
    end else begin
      if (w_do_sel) begin
        r_gnt_sel  <= NPORT'(1) << w_sel_idx;
        r_gnt_last <= req_last[w_sel_idx];
        r_sel_idx  <= w_sel_idx;
      end
      if (r_state == S_REFILL) begin
        for (int unsigned i = 0; i < NPORT; i++) r_credit[i] <= r_weight[i];
      end
      if (w_ack) begin
        if (r_credit[r_sel_idx] != '0) r_credit[r_sel_idx] <= r_credit[r_sel_idx] - WW'(1);
        if (!r_gnt_last) begin
          r_lock      <= 1'b1;
          r_lock_port <= r_sel_idx;
          r_rr_ptr    <= r_sel_idx;
        end else begin
          r_lock   <= 1'b0;
          r_rr_ptr <= (r_credit[r_sel_idx] <= WW'(1)) ? wrap_add(r_sel_idx, 1) : r_sel_idx;
        end
      end
      if (cfg_wr) begin
        r_weight[cfg_port] <= cfg_weight;
        if ((cfg_weight == '0) && (r_lock_port == PW'(cfg_port))) r_lock <= 1'b0;
      end
    end
  end

  assign gnt_valid = (r_state == S_GRANT);
  assign gnt_sel   = r_gnt_sel;
  assign gnt_last  = r_gnt_last;
  assign busy      = (r_state != S_IDLE);

endmodule
